// File: rtl/acc_job_scheduler_if.sv
// Instruction-source and accelerator-side signals of acc_job_scheduler.
// slave = scheduler side, master = instruction source / accelerators.
interface acc_job_scheduler_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [31:0]   instruction;
    logic          instr_valid;
    logic          instr_ready;
    logic          fft_read_done;
    logic          fft_write_done;
    logic          fir_read_done;
    logic          fir_write_done;
    logic          fft_enable;
    logic          fir_enable;
    logic          acc_done;
    logic          acc_error;
    logic [1:0]    acc_op;
    logic          busy;
    logic [CW-1:0] queue_count;

    modport slave (
        input  instruction, instr_valid,
        input  fft_read_done, fft_write_done,
        input  fir_read_done, fir_write_done,
        output instr_ready, fft_enable, fir_enable,
        output acc_done, acc_error, acc_op,
        output busy, queue_count
    );

    modport master (
        output instruction, instr_valid,
        output fft_read_done, fft_write_done,
        output fir_read_done, fir_write_done,
        input  instr_ready, fft_enable, fir_enable,
        input  acc_done, acc_error, acc_op,
        input  busy, queue_count
    );
endinterface

// File: rtl/acc_job_scheduler.sv
// Queues accelerator instructions and runs them one at a time on FFT/FIR.
// Optional per-job watchdog is built when ACC_TIMEOUT_EN is defined.
module acc_job_scheduler #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               reset,
    acc_job_scheduler_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [1:0] OP_FFT = 2'b01;
    localparam logic [1:0] OP_FIR = 2'b10;

    typedef enum logic [2:0] {
        IDLE, RUN_RD, RUN_WR, DONE, ERR
    } state_e;

    state_e        state_q;
    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;
    logic [1:0]    head_op;
    logic          unused_head;
    logic [1:0]    op_q, acc_op_q;
    logic          fft_en_q, fir_en_q;
    logic          done_q, err_q;
    logic          rd_done, wr_done, timeout;

    assign bus.instr_ready = count_q < CW'(FIFO_DEPTH);
    assign push    = bus.instr_valid && bus.instr_ready;
    assign pop     = (state_q == IDLE) && (count_q != '0);
    assign head_op = mem_q[rd_ptr_q][1:0];
    assign unused_head = ^mem_q[rd_ptr_q][31:2];

    // Only the selected accelerator's completion levels matter.
    assign rd_done = (op_q == OP_FFT) ? bus.fft_read_done
                                      : bus.fir_read_done;
    assign wr_done = (op_q == OP_FFT) ? bus.fft_write_done
                                      : bus.fir_write_done;

    assign bus.fft_enable  = fft_en_q;
    assign bus.fir_enable  = fir_en_q;
    assign bus.acc_done    = done_q;
    assign bus.acc_error   = err_q;
    assign bus.acc_op      = acc_op_q;
    assign bus.busy        = state_q != IDLE;
    assign bus.queue_count = count_q;

    // Next FIFO pointers and occupancy.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    // FIFO storage; contents need no reset, the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.instruction;
        end
    end

    // FIFO pointers and count; reset flushes the queue.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef ACC_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wdog_q;

    assign timeout = wdog_q == WW'(TIMEOUT_CYCLES - 1);

    // Watchdog restarts for each awaited done and idles at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_q <= '0;
        end else if (state_q == RUN_RD) begin
            wdog_q <= rd_done ? '0 : wdog_q + WW'(1);
        end else if (state_q == RUN_WR) begin
            wdog_q <= wdog_q + WW'(1);
        end else begin
            wdog_q <= '0;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    // Job FSM with registered enables and status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= 2'b00;
            acc_op_q <= 2'b00;
            fft_en_q <= 1'b0;
            fir_en_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        op_q <= head_op;
                        if (head_op == OP_FFT || head_op == OP_FIR) begin
                            state_q  <= RUN_RD;
                            fft_en_q <= head_op == OP_FFT;
                            fir_en_q <= head_op == OP_FIR;
                        end else begin
                            state_q  <= ERR;
                            err_q    <= 1'b1;
                            acc_op_q <= head_op;
                        end
                    end
                end
                RUN_RD: begin
                    if (rd_done && wr_done) begin
                        state_q  <= DONE;
                        fft_en_q <= 1'b0;
                        fir_en_q <= 1'b0;
                        done_q   <= 1'b1;
                        acc_op_q <= op_q;
                    end else if (rd_done) begin
                        state_q <= RUN_WR;
                    end else if (timeout) begin
                        state_q  <= ERR;
                        fft_en_q <= 1'b0;
                        fir_en_q <= 1'b0;
                        err_q    <= 1'b1;
                        acc_op_q <= op_q;
                    end
                end
                RUN_WR: begin
                    if (wr_done) begin
                        state_q  <= DONE;
                        fft_en_q <= 1'b0;
                        fir_en_q <= 1'b0;
                        done_q   <= 1'b1;
                        acc_op_q <= op_q;
                    end else if (timeout) begin
                        state_q  <= ERR;
                        fft_en_q <= 1'b0;
                        fir_en_q <= 1'b0;
                        err_q    <= 1'b1;
                        acc_op_q <= op_q;
                    end
                end
                DONE, ERR: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_acc_job_scheduler.sv
// Directed self-checking bench for acc_job_scheduler.
// Timeout sequence runs only when ACC_TIMEOUT_EN is defined.
module tb_acc_job_scheduler;
    typedef struct {
        logic [31:0] word;
        int          rd_wait;
        int          wr_wait;
        logic        both;
        logic        wr_first;
        logic        noise;
        logic [1:0]  exp_op;
        logic        exp_err;
    } vec_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   overlap;
    int   n_done;
    int   n_err;
    vec_t vecs [6];

    acc_job_scheduler_if #(.FIFO_DEPTH(4)) bus ();

    acc_job_scheduler #(
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.fft_enable && bus.fir_enable) overlap++;
        if (bus.acc_done) n_done++;
        if (bus.acc_error) n_err++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic rd,
                         input logic wr, input logic nz);
        if (op == 2'b01) begin
            bus.fft_read_done  = rd;
            bus.fft_write_done = wr;
            bus.fir_read_done  = nz;
            bus.fir_write_done = nz;
        end else begin
            bus.fir_read_done  = rd;
            bus.fir_write_done = wr;
            bus.fft_read_done  = nz;
            bus.fft_write_done = nz;
        end
    endtask

    function automatic logic [1:0] en_of(input logic [1:0] op);
        return (op == 2'b01) ? 2'b10 : 2'b01;
    endfunction

    // Push one job into an idle, empty scheduler and run it to the end.
    task automatic run_job(input vec_t v);
        logic [1:0] enx;
        enx = en_of(v.exp_op);
        bus.instruction = v.word;
        bus.instr_valid = 1'b1;
        step();
        bus.instr_valid = 1'b0;
        bus.instruction = '0;
        chk("push_count", bus.queue_count, 1);
        step();
        if (v.exp_err) begin
            chk("err_pulse", bus.acc_error, 1);
            chk("err_op", bus.acc_op, v.exp_op);
            chk("err_en", {bus.fft_enable, bus.fir_enable}, 0);
            chk("err_count", bus.queue_count, 0);
            step();
            chk("err_clear", {bus.acc_error, bus.busy,
                              bus.fft_enable, bus.fir_enable}, 0);
            chk("err_hold", bus.acc_op, v.exp_op);
        end else begin
            chk("run_en", {bus.fft_enable, bus.fir_enable}, enx);
            for (int i = 0; i < v.rd_wait; i++) begin
                drive(v.exp_op, 1'b0, v.wr_first && i == 0, v.noise);
                step();
                chk("rd_wait", {bus.fft_enable, bus.fir_enable,
                                bus.acc_done}, {enx, 1'b0});
            end
            if (v.both) begin
                drive(v.exp_op, 1'b1, 1'b1, v.noise);
                step();
            end else begin
                drive(v.exp_op, 1'b1, 1'b0, v.noise);
                step();
                chk("rd_to_wr", {bus.fft_enable, bus.fir_enable,
                                 bus.acc_done}, {enx, 1'b0});
                for (int i = 0; i < v.wr_wait; i++) begin
                    drive(v.exp_op, 1'b0, 1'b0, v.noise);
                    step();
                    chk("wr_wait", {bus.fft_enable, bus.fir_enable,
                                    bus.acc_done}, {enx, 1'b0});
                end
                drive(v.exp_op, 1'b0, 1'b1, v.noise);
                step();
            end
            drive(v.exp_op, 1'b0, 1'b0, 1'b0);
            chk("done_pulse", {bus.acc_done, bus.fft_enable,
                               bus.fir_enable}, 3'b100);
            chk("done_op", bus.acc_op, v.exp_op);
            step();
            chk("done_clear", {bus.acc_done, bus.busy}, 0);
            chk("op_hold", bus.acc_op, v.exp_op);
        end
    endtask

    initial begin
        int   cnt;
        int   gap;
        int   snap_d;
        int   snap_e;
        logic [1:0] ops [3];
        vec_t v;

        vecs[0] = '{32'h0000_0001, 3, 4, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0};
        vecs[1] = '{32'h0000_0002, 2, 0, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0};
        vecs[2] = '{32'hABCD_0001, 1, 2, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0};
        vecs[3] = '{32'h0000_0003, 0, 0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1};
        vecs[4] = '{32'h1234_5670, 0, 0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1};
        vecs[5] = '{32'hFFFF_FFFE, 0, 1, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0};
        ops[0] = 2'b10;
        ops[1] = 2'b01;
        ops[2] = 2'b10;

        total = 0;
        bad = 0;
        overlap = 0;
        n_done = 0;
        n_err = 0;
        reset = 1'b1;
        bus.instruction = '0;
        bus.instr_valid = 1'b0;
        drive(2'b01, 1'b0, 1'b0, 1'b0);
        step();
        step();
        reset = 1'b0;
        chk("rst_outs", {bus.fft_enable, bus.fir_enable, bus.acc_done,
                         bus.acc_error, bus.acc_op, bus.busy}, 0);
        chk("rst_count", bus.queue_count, 0);
        chk("rst_ready", bus.instr_ready, 1);
        step();

        // Single jobs from the vector table.
        for (int i = 0; i < 6; i++) begin
            run_job(vecs[i]);
            step();
        end

        // Back-to-back FIR, FFT, FIR jobs.
        for (int i = 0; i < 3; i++) begin
            bus.instruction = {30'd0, ops[i]};
            bus.instr_valid = 1'b1;
            step();
        end
        bus.instr_valid = 1'b0;
        cnt = 0;
        while (!(bus.fft_enable || bus.fir_enable) && cnt < 10) begin
            step();
            cnt++;
        end
        for (int j = 0; j < 3; j++) begin
            chk("b2b_en", {bus.fft_enable, bus.fir_enable},
                en_of(ops[j]));
            drive(ops[j], 1'b1, 1'b1, 1'b0);
            step();
            drive(ops[j], 1'b0, 1'b0, 1'b0);
            chk("b2b_done", bus.acc_done, 1);
            chk("b2b_op", bus.acc_op, ops[j]);
            if (j < 2) begin
                gap = 1;
                for (int k = 0; k < 10; k++) begin
                    step();
                    if (bus.fft_enable || bus.fir_enable) break;
                    gap++;
                end
                chk("b2b_gap", gap, 2);
            end
        end
        step();
        chk("b2b_idle", {bus.busy, bus.queue_count}, 0);
        step();

        // Fill the queue behind a stalled FFT job.
        bus.instruction = 32'h1;
        bus.instr_valid = 1'b1;
        step();
        bus.instr_valid = 1'b0;
        step();
        chk("full_run", {bus.fft_enable, bus.fir_enable}, 2'b10);
        for (int i = 0; i < 4; i++) begin
            bus.instruction = (i % 2 == 0) ? 32'h2 : 32'h1;
            bus.instr_valid = 1'b1;
            step();
        end
        chk("full_count", bus.queue_count, 4);
        chk("full_ready", bus.instr_ready, 0);
        bus.instruction = 32'h3;
        step();
        bus.instr_valid = 1'b0;
        chk("fifth_rejected", bus.queue_count, 4);
        drive(2'b01, 1'b1, 1'b1, 1'b0);
        step();
        drive(2'b01, 1'b0, 1'b0, 1'b0);
        chk("full_done_op", {bus.acc_done, bus.acc_op}, 3'b101);
        step();
        chk("full_idle", {bus.queue_count, bus.instr_ready}, {3'd4, 1'b0});
        step();
        chk("pop_ready", {bus.queue_count, bus.instr_ready}, {3'd3, 1'b1});
        chk("pop_fir", {bus.fft_enable, bus.fir_enable}, 2'b01);
        drive(2'b10, 1'b1, 1'b1, 1'b0);
        step();
        drive(2'b10, 1'b0, 1'b0, 1'b0);
        chk("drain_op", {bus.acc_done, bus.acc_op}, 3'b110);
        step();
        step();
        chk("two_queued", bus.queue_count, 2);
        drive(2'b01, 1'b1, 1'b0, 1'b0);
        step();
        drive(2'b01, 1'b0, 1'b0, 1'b0);
        chk("in_run_wr", {bus.fft_enable, bus.busy}, 2'b11);

        // Reset while the job waits for write_done.
        snap_d = n_done;
        snap_e = n_err;
        reset = 1'b1;
        step();
        chk("mid_rst_outs", {bus.fft_enable, bus.fir_enable, bus.acc_done,
                             bus.acc_error, bus.acc_op, bus.busy}, 0);
        chk("mid_rst_q", {bus.queue_count, bus.instr_ready}, 1);
        step();
        reset = 1'b0;
        drive(2'b01, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step();
        drive(2'b01, 1'b0, 1'b0, 1'b0);
        chk("rst_no_pulse", {n_done - snap_d, n_err - snap_e}, 0);
        chk("rst_stays_idle", {bus.busy, bus.queue_count}, 0);
        v = '{32'h0000_0002, 1, 1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0};
        run_job(v);
        step();

`ifdef ACC_TIMEOUT_EN
        // FFT job that never completes trips the watchdog.
        bus.instruction = 32'h1;
        bus.instr_valid = 1'b1;
        step();
        bus.instr_valid = 1'b0;
        step();
        chk("tmo_en", bus.fft_enable, 1);
        cnt = 0;
        while (!bus.acc_error && cnt < 100) begin
            step();
            cnt++;
        end
        chk("tmo_cycles", cnt, 16);
        chk("tmo_state", {bus.acc_error, bus.fft_enable, bus.acc_op},
            4'b1001);
        step();
        chk("tmo_clear", {bus.acc_error, bus.busy}, 0);
        run_job(vecs[1]);
        step();
`endif

        chk("enable_overlap", overlap, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
